// File: rtl/hazard_fwd_ctrl.sv
// Forwarding select, load-use stall and long-latency scoreboard stall
// for the 5-stage RV32 pipeline; sits beside ID/EX.
module hazard_fwd_ctrl #(
    parameter int NUM_RS = 2,
    parameter int AW     = 5,
    parameter int MC_LAT = 4,
    parameter int CNT_W  = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_RS*AW-1:0] ID_RS,
    input  logic [NUM_RS*AW-1:0] ID_EX_RS,
    input  logic [AW-1:0]        ID_EX_RD,
    input  logic                 ID_EX_LOAD,
    input  logic [AW-1:0]        EX_MEM_RD,
    input  logic                 EX_MEM_WRITE,
    input  logic [AW-1:0]        MEM_WB_RD,
    input  logic                 MEM_WB_WRITE,
    input  logic                 MC_ISSUE,
    input  logic [AW-1:0]        MC_RD,
    output logic [NUM_RS*2-1:0]  FWD_SEL,
    output logic                 STALL,
    output logic                 MC_BUSY,
    output logic [31:0]          STALL_CYCLES
);

    localparam int NREG = 2 ** AW;

    logic [CNT_W-1:0] cnt_q [NREG];
    logic [CNT_W-1:0] cnt_d [NREG];
    logic [NREG-1:0]  busy;
    logic [31:0]      stall_cnt_q;
    logic             mc_valid;
    logic             lu_stall;
    logic             sb_stall;

    assign mc_valid = MC_ISSUE && (MC_RD != '0);

    always_comb begin
        busy = '0;
        for (int r = 1; r < NREG; r++) begin
            busy[r] = (cnt_q[r] != '0);
        end
    end

    // A reissue to a busy register reloads the full latency (WAW).
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            cnt_d[r] = cnt_q[r];
            if (cnt_q[r] != '0) begin
                cnt_d[r] = cnt_q[r] - 1'b1;
            end
            if (mc_valid && (MC_RD == AW'(r))) begin
                cnt_d[r] = CNT_W'(MC_LAT);
            end
        end
        cnt_d[0] = '0;
    end

    always_comb begin
        FWD_SEL = '0;
        for (int k = 0; k < NUM_RS; k++) begin
            if (MEM_WB_WRITE && (MEM_WB_RD != '0)
                && (MEM_WB_RD == ID_EX_RS[k*AW +: AW])) begin
                FWD_SEL[k*2 +: 2] = 2'b01;
            end
            if (EX_MEM_WRITE && (EX_MEM_RD != '0)
                && (EX_MEM_RD == ID_EX_RS[k*AW +: AW])) begin
                FWD_SEL[k*2 +: 2] = 2'b10;
            end
        end
        if (rst) begin
            FWD_SEL = '0;
        end
    end

    always_comb begin
        lu_stall = 1'b0;
        sb_stall = 1'b0;
        for (int k = 0; k < NUM_RS; k++) begin
            if (ID_EX_LOAD && (ID_EX_RD != '0)
                && (ID_EX_RD == ID_RS[k*AW +: AW])) begin
                lu_stall = 1'b1;
            end
            if (busy[ID_RS[k*AW +: AW]]) begin
                sb_stall = 1'b1;
            end
            // Same-cycle issue bypass: the entry is not yet visible in cnt_q.
            if (mc_valid && (MC_RD == ID_RS[k*AW +: AW])) begin
                sb_stall = 1'b1;
            end
        end
    end

    assign STALL        = !rst && (lu_stall || sb_stall);
    assign MC_BUSY      = !rst && (|busy);
    assign STALL_CYCLES = stall_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= '0;
            end
            stall_cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (STALL && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

endmodule
